dmem_sram_bridge: RTL and testbench
===================================

Name: dmem_sram_bridge

Overview:
- Responder for the memory stage's data-memory port: accepts the memory stage's read/write request (mread/mwrite) and returns read data (rd) plus the d_data_ok handshake to hazard control.
- Converts each request into one transaction on the NSCSCC SRAM-like data bus (req/addr_ok/data_ok).
- Holds results stable until the pipeline advances.
- Drains in-flight bus transactions safely across exception flushes.

Parameters:
- MAP_KSEG, 1, when 1 map kseg0/kseg1 addresses (0x8000_0000-0xBFFF_FFFF) to physical by clearing addr[31:29]; when 0 pass addresses through.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- mread  input  m_r_t  read request: ren, addr[31:0], size[1:0].
- mwrite  input  m_w_t  write request: wen, addr[31:0], size[1:0], wd[31:0].
- stall  input  1  stallM from hazard; 0 means the memory stage advances this cycle.
- flush  input  1  exception flush; kills the current memory-stage request.
- rd  output  32  raw read word, registered.
- d_data_ok  output  1  request complete, or no request pending.
- data_req  output  1  SRAM-like request valid.
- data_wr  output  1  1 means write.
- data_size  output  2  0 = byte, 1 = half, 2 = word.
- data_addr  output  32  physical address.
- data_wdata  output  32  write data, unshifted.
- data_addr_ok  input  1  address accepted.
- data_data_ok  input  1  data phase complete.
- data_rdata  input  32  read data.

Behaviour:
- Clocking: single clock, clk. Synchronous active-high reset: state = IDLE, kill = 0, rd = 0, data_req = 0, data_wr = 0, data_size = 0, data_addr = 0, data_wdata = 0.
- Request present: pend = mread.ren | mwrite.wen. wen has priority if both are set; that case is illegal and the bench asserts on it.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - If pend and not flush: latch wr/size/mapped addr/wd into the bus registers and go to ADDR.
  - Otherwise stay.
  - If flush is asserted, nothing is issued.
- ADDR:
  - data_req = 1. Bus fields are held constant until data_addr_ok; the request is never withdrawn, even under flush.
  - On data_addr_ok: next state is DATA. If data_data_ok arrives in the same cycle, capture and go straight to DONE, or to IDLE if kill is set.
- DATA:
  - data_req = 0; wait for data_data_ok.
  - On data_data_ok: if kill, go to IDLE and discard rdata. Otherwise load rd from data_rdata (reads only; writes leave rd unchanged) and go to DONE.
- DONE:
  - Result is held.
  - If (not stall) or flush: go to IDLE. The next request is examined in the following cycle, so there is a minimum of 1 idle cycle between transactions.
- kill flag:
  - Set when flush is sampled in ADDR or DATA.
  - Cleared on every entry to IDLE.
- d_data_ok (combinational) = (state == DONE) | (state == IDLE & ~pend). It is 0 in ADDR and DATA, and 0 in IDLE while a request is pending.
- Latency: minimum 3 cycles from request to d_data_ok (issue, addr_ok+data_ok, DONE). Each added bus wait cycle adds one.
- Address mapping: with MAP_KSEG = 1, 0x9FC0_1234 maps to 0x1FC0_1234 and 0xA000_0040 maps to 0x0000_0040. kuseg and kseg2/3 pass through unchanged.
- Stability: rd changes only on a non-killed read data_ok.
- Reset mid-transaction: return to IDLE immediately. Any stray data_ok seen after reset is ignored, because IDLE ignores bus responses.

Decomposition:
- Shared package (mips.svh): m_r_t, m_w_t field layout; size encodings (MSIZE_B/H/W); the KSEG mapping function map_paddr().
- Local typedef for the FSM state enum.
- No sub-module; address mapping is a package function.

Test Plan:
- Word read, zero wait: mread = {1, 0x8000_0010, W}, addr_ok and data_ok in the same cycle, rdata = 0xDEAD_BEEF -> data_addr = 0x0000_0010, rd = 0xDEAD_BEEF, d_data_ok high 3 cycles after request; held while stall = 1, low cycle after stall drops.
- Byte write with waits: mwrite = {1, 0xBFAF_F000, B, 0x0000_00A5}, addr_ok after 2 cycles, data_ok 3 cycles later -> data_req held 3 cycles with fixed fields, data_wr = 1, data_addr = 0x1FAF_F000, rd unchanged, d_data_ok only in DONE.
- Flush in DATA: read issued, flush pulsed before data_ok, rdata = 0x1234_5678 -> rd keeps its previous value, FSM returns to IDLE, d_data_ok = 1 afterward with no request.
- Flush in ADDR: data_addr_ok withheld 4 cycles, flush in cycle 1 -> data_req stays 1 until addr_ok, then data drained and discarded, no DONE.
- Back-to-back: two reads at 0x0000_0100 and 0x0000_0104, each answered immediately -> exactly two data_req handshakes, at least one IDLE cycle between them, each rd correct.
- Reset mid-ADDR: reset asserted while data_req = 1 -> next cycle all outputs 0, state IDLE; a data_ok asserted after reset changes nothing.

Source files
------------

// File: rtl/dmem_sram_bridge_pkg.sv
// Shared memory-stage request layouts, access size encodings and the
// kseg0/kseg1 virtual-to-physical address mapping helper.
package dmem_sram_bridge_pkg;

  localparam logic [1:0] MSIZE_B = 2'd0;
  localparam logic [1:0] MSIZE_H = 2'd1;
  localparam logic [1:0] MSIZE_W = 2'd2;

  typedef struct packed {
    logic        ren;
    logic [31:0] addr;
    logic [1:0]  size;
  } m_r_t;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wd;
  } m_w_t;

  // kseg0 (0x8xxx_xxxx/0x9xxx_xxxx) and kseg1 (0xAxxx_xxxx/0xBxxx_xxxx) alias low
  // physical memory, so dropping the top three bits yields the physical address.
  function automatic logic [31:0] map_paddr(input logic [31:0] vaddr, input logic map_kseg);
    logic [31:0] paddr;
    paddr = vaddr;
    if (map_kseg && (vaddr[31:30] == 2'b10)) begin
      paddr[31:29] = 3'b000;
    end
    return paddr;
  endfunction

endpackage

// File: rtl/dmem_sram_bridge.sv
// Data-memory responder: turns one memory-stage request into a single SRAM-like
// bus transaction, holds the result until the pipeline moves on, drains on flush.
module dmem_sram_bridge
  import dmem_sram_bridge_pkg::*;
#(
  parameter logic MAP_KSEG = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  m_r_t        mread,
  input  m_w_t        mwrite,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] rd,
  output logic        d_data_ok,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  state_t state, state_nx;
  logic   kill, kill_nx;
  logic   pend;
  logic   kill_eff;
  logic   issue;
  logic   capture;

  assign pend     = mread.ren | mwrite.wen;
  // A flush seen in the completing cycle is treated the same as an earlier one.
  assign kill_eff = kill | flush;

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (pend && !flush) begin
          issue    = 1'b1;
          state_nx = ADDR;
        end
      end
      ADDR: begin
        if (data_addr_ok) begin
          if (data_data_ok) begin
            capture  = 1'b1;
            state_nx = kill_eff ? IDLE : DONE;
          end else begin
            state_nx = DATA;
          end
        end
      end
      DATA: begin
        if (data_data_ok) begin
          capture  = 1'b1;
          state_nx = kill_eff ? IDLE : DONE;
        end
      end
      DONE: begin
        if (!stall || flush) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // The in-flight transaction cannot be withdrawn, so a flush only marks its
    // result for discard; the mark dies whenever the FSM is back in IDLE.
    kill_nx = kill;
    if (state_nx == IDLE) begin
      kill_nx = 1'b0;
    end else if ((state == ADDR || state == DATA) && flush) begin
      kill_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      kill       <= 1'b0;
      rd         <= 32'd0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= 32'd0;
      data_wdata <= 32'd0;
    end else begin
      state <= state_nx;
      kill  <= kill_nx;
      // Write wins if both request bits are ever set together.
      if (issue) begin
        data_wr    <= mwrite.wen;
        data_size  <= mwrite.wen ? mwrite.size : mread.size;
        data_addr  <= map_paddr(mwrite.wen ? mwrite.addr : mread.addr, MAP_KSEG);
        data_wdata <= mwrite.wd;
      end
      if (capture && !kill_eff && !data_wr) begin
        rd <= data_rdata;
      end
    end
  end

  assign data_req  = (state == ADDR);
  assign d_data_ok = (state == DONE) | ((state == IDLE) & ~pend);

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Bench for dmem_sram_bridge: table of bus transactions with a result scoreboard,
// followed by flush, back-to-back and reset corner sequences.
module tb_dmem_sram_bridge;
  import dmem_sram_bridge_pkg::*;

  logic        clk;
  logic        reset;
  m_r_t        mread;
  m_w_t        mwrite;
  logic        stall;
  logic        flush;
  logic [31:0] rd;
  logic        d_data_ok;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  dmem_sram_bridge #(.MAP_KSEG(1'b1)) dut (
    .clk(clk), .reset(reset), .mread(mread), .mwrite(mwrite), .stall(stall), .flush(flush),
    .rd(rd), .d_data_ok(d_data_ok), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    assert (!(mread.ren && mwrite.wen)) else $error("read and write requested together");
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wd;
    int          aw;
    int          dw;
    logic [31:0] rdata;
    logic [31:0] paddr;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] exp_q[$];
  logic [31:0] model_rd;
  int          n_cmp;
  int          n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_req();
    mread  = '0;
    mwrite = '0;
  endtask

  task automatic present(input vec_t v);
    if (v.wr) begin
      mread  = '0;
      mwrite = '{wen: 1'b1, addr: v.addr, size: v.size, wd: v.wd};
    end else begin
      mwrite = '0;
      mread  = '{ren: 1'b1, addr: v.addr, size: v.size};
      model_rd = v.rdata;
    end
    exp_q.push_back(model_rd);
  endtask

  // Entered at a negedge in IDLE with the request presented; returns at a negedge
  // in DONE after one extra stalled cycle.
  task automatic run_bus(input vec_t v);
    int req_cycles;
    logic [31:0] exp_rd;
    req_cycles = 0;
    stall = 1'b1;
    #1;
    chk("pend_ddok_low", {31'd0, d_data_ok}, 32'd0);
    chk("idle_no_req", {31'd0, data_req}, 32'd0);
    @(negedge clk);
    for (int i = 0; i <= v.aw; i++) begin
      if (data_req) req_cycles++;
      chk("addr_ddok_low", {31'd0, d_data_ok}, 32'd0);
      chk("bus_addr", data_addr, v.paddr);
      chk("bus_wr", {31'd0, data_wr}, {31'd0, v.wr});
      chk("bus_size", {30'd0, data_size}, {30'd0, v.size});
      if (v.wr) chk("bus_wdata", data_wdata, v.wd);
      if (i == v.aw) begin
        data_addr_ok = 1'b1;
        if (v.dw == 0) begin
          data_data_ok = 1'b1;
          data_rdata   = v.rdata;
        end
      end
      @(negedge clk);
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
    end
    for (int i = 1; i <= v.dw; i++) begin
      chk("data_req_low", {31'd0, data_req}, 32'd0);
      chk("data_ddok_low", {31'd0, d_data_ok}, 32'd0);
      if (i == v.dw) begin
        data_data_ok = 1'b1;
        data_rdata   = v.rdata;
      end
      @(negedge clk);
      data_data_ok = 1'b0;
    end
    chk("req_cycles", req_cycles, v.aw + 1);
    chk("done_ddok", {31'd0, d_data_ok}, 32'd1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      exp_rd = model_rd;
    end else begin
      exp_rd = exp_q.pop_front();
    end
    chk("done_rd", rd, exp_rd);
    data_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("hold_ddok", {31'd0, d_data_ok}, 32'd1);
    chk("hold_rd", rd, exp_rd);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_rd = 32'd0;
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'd0;
    clear_req();

    vecs[0] = '{1'b0, 32'h8000_0010, MSIZE_W, 32'd0,          0, 0, 32'hDEAD_BEEF, 32'h0000_0010};
    vecs[1] = '{1'b1, 32'hBFAF_F000, MSIZE_B, 32'h0000_00A5,  2, 3, 32'h0BAD_0001, 32'h1FAF_F000};
    vecs[2] = '{1'b0, 32'h9FC0_1234, MSIZE_H, 32'd0,          1, 1, 32'h0000_CAFE, 32'h1FC0_1234};
    vecs[3] = '{1'b0, 32'hA000_0040, MSIZE_W, 32'd0,          0, 2, 32'h1111_2222, 32'h0000_0040};
    vecs[4] = '{1'b1, 32'h0000_0200, MSIZE_W, 32'h55AA_55AA,  0, 0, 32'h0BAD_0002, 32'h0000_0200};
    vecs[5] = '{1'b0, 32'hC000_0008, MSIZE_W, 32'd0,          0, 0, 32'h3333_4444, 32'hC000_0008};
    vecs[6] = '{1'b0, 32'h0000_0100, MSIZE_W, 32'd0,          0, 0, 32'hAAAA_0001, 32'h0000_0100};
    vecs[7] = '{1'b0, 32'h0000_0104, MSIZE_W, 32'd0,          0, 0, 32'hAAAA_0002, 32'h0000_0104};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ddok", {31'd0, d_data_ok}, 32'd1);
    chk("rst_req", {31'd0, data_req}, 32'd0);
    chk("rst_rd", rd, 32'd0);
    chk("rst_addr", data_addr, 32'd0);
    @(negedge clk);

    // Table: each transaction's stall release presents the next request, so the
    // entry check of run_bus also sees the mandatory idle cycle.
    present(vecs[0]);
    for (int i = 0; i < 8; i++) begin
      run_bus(vecs[i]);
      stall = 1'b0;
      if (i < 7) present(vecs[i + 1]);
      else clear_req();
      @(negedge clk);
    end
    chk("end_idle_ddok", {31'd0, d_data_ok}, 32'd1);
    chk("end_idle_req", {31'd0, data_req}, 32'd0);

    // Flush while idle: nothing is issued.
    mread = '{ren: 1'b1, addr: 32'h0000_0600, size: MSIZE_W};
    flush = 1'b1;
    #1;
    chk("iflush_ddok", {31'd0, d_data_ok}, 32'd0);
    @(negedge clk);
    chk("iflush_no_req", {31'd0, data_req}, 32'd0);
    flush = 1'b0;
    clear_req();
    #1;
    chk("iflush_idle_ddok", {31'd0, d_data_ok}, 32'd1);
    @(negedge clk);

    // Flush in DATA: read data arrives but is discarded.
    stall = 1'b1;
    mread = '{ren: 1'b1, addr: 32'h0000_0300, size: MSIZE_W};
    @(negedge clk);
    chk("dflush_req", {31'd0, data_req}, 32'd1);
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    chk("dflush_data_req", {31'd0, data_req}, 32'd0);
    flush = 1'b1;
    clear_req();
    @(negedge clk);
    flush = 1'b0;
    chk("dflush_wait_ddok", {31'd0, d_data_ok}, 32'd0);
    data_data_ok = 1'b1;
    data_rdata   = 32'h1234_5678;
    @(negedge clk);
    data_data_ok = 1'b0;
    chk("dflush_idle_ddok", {31'd0, d_data_ok}, 32'd1);
    chk("dflush_rd", rd, model_rd);
    chk("dflush_no_req", {31'd0, data_req}, 32'd0);
    @(negedge clk);

    // Flush in ADDR: request held until accepted, then drained without DONE.
    mread = '{ren: 1'b1, addr: 32'h0000_0400, size: MSIZE_W};
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("aflush_req_held", {31'd0, data_req}, 32'd1);
      chk("aflush_addr", data_addr, 32'h0000_0400);
      if (i == 1) begin
        flush = 1'b1;
        clear_req();
      end
      @(negedge clk);
      flush = 1'b0;
    end
    chk("aflush_req_last", {31'd0, data_req}, 32'd1);
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    chk("aflush_data_req", {31'd0, data_req}, 32'd0);
    chk("aflush_data_ddok", {31'd0, d_data_ok}, 32'd0);
    data_data_ok = 1'b1;
    data_rdata   = 32'h7777_7777;
    @(negedge clk);
    data_data_ok = 1'b0;
    chk("aflush_idle_ddok", {31'd0, d_data_ok}, 32'd1);
    chk("aflush_rd", rd, model_rd);
    @(negedge clk);

    // Reset mid-ADDR, then a stray data_ok.
    mwrite = '{wen: 1'b1, addr: 32'h8000_0500, size: MSIZE_W, wd: 32'h0000_0001};
    @(negedge clk);
    chk("rreset_req", {31'd0, data_req}, 32'd1);
    reset = 1'b1;
    clear_req();
    @(negedge clk);
    reset = 1'b0;
    model_rd = 32'd0;
    chk("rreset_req0", {31'd0, data_req}, 32'd0);
    chk("rreset_addr0", data_addr, 32'd0);
    chk("rreset_wr0", {31'd0, data_wr}, 32'd0);
    chk("rreset_size0", {30'd0, data_size}, 32'd0);
    chk("rreset_wdata0", data_wdata, 32'd0);
    chk("rreset_rd0", rd, 32'd0);
    chk("rreset_ddok", {31'd0, d_data_ok}, 32'd1);
    data_data_ok = 1'b1;
    data_rdata   = 32'hFFFF_FFFF;
    @(negedge clk);
    data_data_ok = 1'b0;
    chk("stray_rd", rd, 32'd0);
    chk("stray_req", {31'd0, data_req}, 32'd0);
    chk("stray_ddok", {31'd0, d_data_ok}, 32'd1);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
